// File: rtl/stencil_row_window_if.sv
// Pixel-in / window-out handshake bundle for the row window stage.
// master drives pixels and the downstream ready; slave is the window block.
interface stencil_row_window_if #(
    parameter int PW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [PW-1:0]   in_data;
    logic            out_valid;
    logic            out_ready;
    logic [3*PW-1:0] out_data;
    logic            out_row_last;
    logic            out_frame_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_row_last, out_frame_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_row_last, out_frame_last
    );
endinterface

// File: rtl/stencil_row_window.sv
// Raster pixel stream to 3-pixel horizontal windows {p[x], p[x-1], p[x-2]}.
// Windows never straddle a row; last-of-row and last-of-frame are flagged.
module stencil_row_window #(
    parameter int BITS  = 3,
    parameter int IMG_W = 640,
    parameter int IMG_H = 480
) (
    input  logic clk,
    input  logic rst,
    stencil_row_window_if.slave io
);
    localparam int PW = 1 << BITS;
    localparam int CW = $clog2(IMG_W);
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);

    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic [PW-1:0]   tap0_q, tap0_d;
    logic [PW-1:0]   tap1_q, tap1_d;
    logic            valid_q, valid_d;
    logic [3*PW-1:0] data_q, data_d;
    logic            rlast_q, rlast_d;
    logic            flast_q, flast_d;
    logic            accept;
    logic            col_end;
    logic            row_end;

    // Single output register: refill only when it is empty or draining.
    assign io.in_ready = !rst && (!valid_q || io.out_ready);
    assign accept      = io.in_valid && io.in_ready;
    assign col_end     = (col_q == COL_MAX);
    assign row_end     = (row_q == ROW_MAX);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        tap0_d  = tap0_q;
        tap1_d  = tap1_q;
        valid_d = valid_q;
        data_d  = data_q;
        rlast_d = rlast_q;
        flast_d = flast_q;
        if (io.out_ready) begin
            valid_d = 1'b0;
        end
        if (accept) begin
            tap1_d = tap0_q;
            tap0_d = io.in_data;
            if (col_end) begin
                col_d = '0;
                row_d = row_end ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            // First two pixels of a row only prime the taps.
            if (col_q >= CW'(2)) begin
                valid_d = 1'b1;
                data_d  = {io.in_data, tap0_q, tap1_q};
                rlast_d = col_end;
                flast_d = col_end && row_end;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            tap0_q  <= '0;
            tap1_q  <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            rlast_q <= 1'b0;
            flast_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            tap0_q  <= tap0_d;
            tap1_q  <= tap1_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            rlast_q <= rlast_d;
            flast_q <= flast_d;
        end
    end

    assign io.out_valid      = valid_q;
    assign io.out_data       = data_q;
    assign io.out_row_last   = rlast_q;
    assign io.out_frame_last = flast_q;
endmodule

// File: tb/tb_stencil_row_window.sv
// Bench for stencil_row_window with a 5x2 image and 8-bit pixels.
// A negedge monitor scores every window against a raster model.
module tb_stencil_row_window;
    localparam int W = 5;
    localparam int H = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    stencil_row_window_if #(.PW(8)) bus ();

    stencil_row_window #(.BITS(3), .IMG_W(W), .IMG_H(H)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    bit [25:0] sb[$];
    bit [25:0] obs[$];
    bit        mon_en = 1'b0;
    bit        pend = 1'b0;
    bit        hold = 1'b0;
    bit [25:0] hold_v;
    logic [7:0] m_t0, m_t1;
    int        m_col = 0;
    int        m_row = 0;

    // Scoreboard monitor: model pushes on accept, compare on handshake.
    always @(negedge clk) begin
        if (mon_en) begin
            bit [25:0] cur;
            bit [25:0] e;
            cur = {bus.out_data, bus.out_row_last, bus.out_frame_last};
            if (pend) begin
                n_cmp++;
                if (bus.out_valid !== 1'b1) begin
                    n_bad++;
                    $display("FAIL latency: out_valid=%b required 1", bus.out_valid);
                end
                pend = 1'b0;
            end
            if (hold) begin
                n_cmp++;
                if (cur !== hold_v) begin
                    n_bad++;
                    $display("FAIL stable: got %h required %h", cur, hold_v);
                end
            end
            if (bus.out_valid === 1'b1 && bus.out_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_window: got %h required none", cur);
                end else begin
                    e = sb.pop_front();
                    if (cur !== e) begin
                        n_bad++;
                        $display("FAIL window: got %h required %h", cur, e);
                    end
                end
                obs.push_back(cur);
            end
            hold   = (bus.out_valid === 1'b1) && !bus.out_ready && !rst;
            hold_v = cur;
            if (rst) begin
                m_col = 0;
                m_row = 0;
                m_t0  = '0;
                m_t1  = '0;
                sb.delete();
                pend  = 1'b0;
                hold  = 1'b0;
            end else if (bus.in_valid && bus.in_ready) begin
                if (m_col >= 2) begin
                    sb.push_back({bus.in_data, m_t0, m_t1,
                                  m_col == W-1, m_col == W-1 && m_row == H-1});
                    pend = 1'b1;
                end
                m_t1 = m_t0;
                m_t0 = bus.in_data;
                if (m_col == W-1) begin
                    m_col = 0;
                    m_row = (m_row == H-1) ? 0 : m_row + 1;
                end else begin
                    m_col++;
                end
            end
        end
    end

    task automatic send(input logic [7:0] d);
        int guard;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 200) begin
            guard++;
            @(negedge clk);
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL send_timeout: in_ready=%b required 1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bus.in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        obs.delete();
    endtask

    task automatic test_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h55;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            n_cmp++;
            if ({bus.out_valid, bus.out_data, bus.out_row_last,
                 bus.out_frame_last, bus.in_ready} !== 28'h0) begin
                n_bad++;
                $display("FAIL reset_values: v=%b d=%h rl=%b fl=%b rdy=%b required all 0",
                         bus.out_valid, bus.out_data, bus.out_row_last,
                         bus.out_frame_last, bus.in_ready);
            end
        end
        #1;
        bus.in_valid = 1'b0;
        rst          = 1'b0;
    endtask

    task automatic test_stream();
        bit [25:0] exp[3];
        exp = '{{24'h030201, 2'b00}, {24'h040302, 2'b00}, {24'h050403, 2'b10}};
        obs.delete();
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send(8'(i));
        idle(3);
        n_cmp++;
        if (obs.size() != 3) begin
            n_bad++;
            $display("FAIL stream_count: got %0d required 3", obs.size());
        end
        for (int i = 0; i < 3 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL stream_%0d: got %h required %h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_row_boundary();
        bit [25:0] exp[4];
        exp = '{{24'h080706, 2'b00}, {24'h090807, 2'b00},
                {24'h0A0908, 2'b11}, {24'h0D0C0B, 2'b00}};
        obs.delete();
        for (int i = 6; i <= 13; i++) send(8'(i));
        idle(3);
        n_cmp++;
        if (obs.size() != 4) begin
            n_bad++;
            $display("FAIL row_count: got %0d required 4", obs.size());
        end
        for (int i = 0; i < 4 && i < obs.size(); i++) begin
            n_cmp++;
            if (obs[i] !== exp[i]) begin
                n_bad++;
                $display("FAIL row_%0d: got %h required %h", i, obs[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        reset_dut();
        for (int i = 1; i <= 3; i++) send(8'(i));
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h04;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 ||
                bus.out_data !== 24'h030201) begin
                n_bad++;
                $display("FAIL bp_hold: rdy=%b v=%b d=%h required 0 1 030201",
                         bus.in_ready, bus.out_valid, bus.out_data);
            end
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'h04);
        send(8'h05);
        idle(3);
        n_cmp++;
        if (obs.size() != 3 || obs[0] !== {24'h030201, 2'b00} ||
            obs[1] !== {24'h040302, 2'b00} || obs[2] !== {24'h050403, 2'b10}) begin
            n_bad++;
            $display("FAIL bp_order: got %0d windows first %h required 3 from 030201",
                     obs.size(), obs.size() > 0 ? obs[0] : 26'h0);
        end
    endtask

    task automatic test_bubbles();
        int cnt;
        int cyc;
        int rl;
        int fl;
        reset_dut();
        cnt = 0;
        cyc = 0;
        while (cnt < 3*W*H && cyc < 3000) begin
            bus.in_valid  = ($urandom_range(0, 2) != 0);
            bus.in_data   = 8'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) cnt++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus.out_ready = 1'b1;
        idle(4);
        n_cmp++;
        if (cnt != 3*W*H) begin
            n_bad++;
            $display("FAIL bubble_timeout: accepted %0d required %0d", cnt, 3*W*H);
        end
        rl = 0;
        fl = 0;
        foreach (obs[i]) begin
            rl += obs[i][1];
            fl += obs[i][0];
        end
        n_cmp++;
        if (obs.size() != 3*(W-2)*H || rl != 3*H || fl != 3) begin
            n_bad++;
            $display("FAIL bubble_counts: win=%0d rl=%0d fl=%0d required %0d %0d 3",
                     obs.size(), rl, fl, 3*(W-2)*H, 3*H);
        end
    endtask

    task automatic test_midrow_reset();
        reset_dut();
        for (int i = 1; i <= 3; i++) send(8'(i));
        rst          = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_rst_ready: rdy=%b v=%b required 0 1",
                     bus.in_ready, bus.out_valid);
        end
        @(posedge clk);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_rst_valid: got %b required 0", bus.out_valid);
        end
        @(posedge clk);
        #1;
        obs.delete();
        send(8'h14);
        send(8'h15);
        send(8'h16);
        idle(3);
        n_cmp++;
        if (obs.size() != 1 || obs[0] !== {24'h161514, 2'b00}) begin
            n_bad++;
            $display("FAIL mid_rst_window: got %0d windows first %h required 1 of 161514",
                     obs.size(), obs.size() > 0 ? obs[0] : 26'h0);
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        mon_en        = 1'b1;
        test_reset();
        reset_dut();
        test_stream();
        test_row_boundary();
        test_backpressure();
        test_bubbles();
        test_midrow_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
